mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single external memory bus between the fetch stage (I-side) and the memory stage (D-side) of the five-stage MIPS pipeline. It accepts one request at a time, holds the bus until the slave acknowledges, returns read data through registered per-side ports and pulses a one-cycle ready. The pipeline's stall logic keys off the requester's own request and ready signals. It sits between the fetch/mem-stage datapath and the external SRAM/bus bridge.

---
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares one memory bus between fetch (I) and data (D) requesters
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_flush,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_wstrb,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          m_req,
    output logic          m_we,
    output logic [3:0]    m_wstrb,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_I_BUSY = 2'd1;
    localparam logic [1:0] c_D_BUSY = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          discard_q, discard_d;
    logic          m_req_q, m_req_d;
    logic          m_we_q, m_we_d;
    logic [3:0]    m_wstrb_q, m_wstrb_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_ready_q, i_ready_d;
    logic          d_ready_q, d_ready_d;

    // A side whose ready is high this cycle is still deasserting its request.
    logic w_d_elig, w_i_elig;
    assign w_d_elig = d_req && !d_ready_q;
    assign w_i_elig = i_req && !i_ready_q && !i_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (w_d_elig)      state_d = c_D_BUSY;
                else if (w_i_elig) state_d = c_I_BUSY;
            end
            c_I_BUSY, c_D_BUSY: begin
                if (m_ack) state_d = c_IDLE;
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        discard_d = discard_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_wstrb_d = m_wstrb_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (w_d_elig) begin
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_wstrb_d = d_wstrb;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                end else if (w_i_elig) begin
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_wstrb_d = 4'b0000;
                    m_addr_d  = i_addr;
                    discard_d = 1'b0;
                end
            end
            c_I_BUSY: begin
                if (m_ack) begin
                    m_req_d   = 1'b0;
                    discard_d = 1'b0;
                    // A flush arriving with the ack still suppresses this completion.
                    if (!(discard_q || i_flush)) begin
                        i_rdata_d = m_rdata;
                        i_ready_d = 1'b1;
                    end
                end else if (i_flush) begin
                    discard_d = 1'b1;
                end
            end
            c_D_BUSY: begin
                if (m_ack) begin
                    m_req_d   = 1'b0;
                    d_rdata_d = m_rdata;
                    d_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            discard_q <= 1'b0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_wstrb_q <= 4'b0000;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
        end else begin
            discard_q <= discard_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_wstrb_q <= m_wstrb_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_wstrb = m_wstrb_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ready = i_ready_q;
    assign d_ready = d_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_flush = 1'b0;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_wstrb = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ack = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .m_req(m_req), .m_we(m_we), .m_wstrb(m_wstrb), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [135:0] outs;
        for (int k = 0; k < 5; k++) begin
            i_req = 1'($urandom); i_addr = $urandom; i_flush = 1'($urandom);
            d_req = 1'($urandom); d_we = 1'($urandom); d_wstrb = 4'($urandom);
            d_addr = $urandom; d_wdata = $urandom;
            m_rdata = $urandom; m_ack = 1'($urandom);
            tick();
            outs = {m_req, m_we, m_wstrb, m_addr, m_wdata, i_rdata, d_rdata, i_ready, d_ready};
            n_total++;
            if (outs !== 136'd0) begin
                n_bad++; $display("FAIL reset_hold cyc%0d: got %h want 0", k, outs);
            end
        end
        i_req = 0; i_flush = 0; d_req = 0; d_we = 0; d_wstrb = 0; m_ack = 0;
        rst = 1'b1;
        #1;
        outs = {m_req, m_we, m_wstrb, m_addr, m_wdata, i_rdata, d_rdata, i_ready, d_ready};
        n_total++;
        if (outs !== 136'd0) begin
            n_bad++; $display("FAIL reset_release: got %h want 0", outs);
        end
        d_req = 1; d_addr = 32'h10; d_we = 0;
        tick();
        n_total++;
        if (m_req !== 1'b1 || m_addr !== 32'h10) begin
            n_bad++; $display("FAIL reset_first_grant: m_req=%b m_addr=%h want 1 00000010", m_req, m_addr);
        end
        m_ack = 1; m_rdata = 32'h0;
        tick();
        m_ack = 0; d_req = 0;
        tick();
    endtask

    task automatic test_single_load();
        d_req = 1; d_addr = 32'h100; d_we = 0; d_wstrb = 4'b0000;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_total++;
            if (m_req !== 1'b1 || m_addr !== 32'h100 || m_we !== 1'b0 || d_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL load_hold c%0d: m_req=%b m_addr=%h m_we=%b d_ready=%b want 1 00000100 0 0",
                         c, m_req, m_addr, m_we, d_ready);
            end
        end
        m_ack = 1; m_rdata = 32'hDEADBEEF;
        tick();
        m_ack = 0; d_req = 0;
        n_total++;
        if (d_ready !== 1'b1 || d_rdata !== 32'hDEADBEEF || m_req !== 1'b0) begin
            n_bad++;
            $display("FAIL load_done: d_ready=%b d_rdata=%h m_req=%b want 1 deadbeef 0", d_ready, d_rdata, m_req);
        end
        tick();
        n_total++;
        if (d_ready !== 1'b0 || d_rdata !== 32'hDEADBEEF || m_req !== 1'b0) begin
            n_bad++;
            $display("FAIL load_after: d_ready=%b d_rdata=%h m_req=%b want 0 deadbeef 0", d_ready, d_rdata, m_req);
        end
    endtask

    task automatic test_contention();
        i_req = 1; i_addr = 32'h400;
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h12345678; d_wstrb = 4'b0011;
        tick();
        n_total++;
        if (m_req !== 1'b1 || m_addr !== 32'h200 || m_we !== 1'b1 || m_wstrb !== 4'b0011 ||
            m_wdata !== 32'h12345678) begin
            n_bad++;
            $display("FAIL cont_store: req=%b addr=%h we=%b strb=%b wdata=%h want 1 00000200 1 0011 12345678",
                     m_req, m_addr, m_we, m_wstrb, m_wdata);
        end
        m_ack = 1; m_rdata = 32'h0;
        tick();
        m_ack = 0; d_req = 0;
        n_total++;
        if (d_ready !== 1'b1 || m_req !== 1'b0 || i_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL cont_dready: d_ready=%b m_req=%b i_ready=%b want 1 0 0", d_ready, m_req, i_ready);
        end
        tick();
        n_total++;
        if (m_req !== 1'b1 || m_addr !== 32'h400 || m_we !== 1'b0 || m_wstrb !== 4'b0000) begin
            n_bad++;
            $display("FAIL cont_fetch: req=%b addr=%h we=%b strb=%b want 1 00000400 0 0000",
                     m_req, m_addr, m_we, m_wstrb);
        end
        m_ack = 1; m_rdata = 32'h11112222;
        tick();
        m_ack = 0; i_req = 0;
        n_total++;
        if (i_ready !== 1'b1 || i_rdata !== 32'h11112222) begin
            n_bad++; $display("FAIL cont_fetch_done: i_ready=%b i_rdata=%h want 1 11112222", i_ready, i_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        i_req = 1; i_addr = 32'h400;
        tick();
        n_total++;
        if (m_req !== 1'b1 || m_addr !== 32'h400) begin
            n_bad++; $display("FAIL b2b_first: m_req=%b m_addr=%h want 1 00000400", m_req, m_addr);
        end
        m_ack = 1; m_rdata = 32'hCAFE0001;
        tick();
        m_ack = 0; i_addr = 32'h404;
        n_total++;
        if (i_ready !== 1'b1 || i_rdata !== 32'hCAFE0001) begin
            n_bad++; $display("FAIL b2b_ready1: i_ready=%b i_rdata=%h want 1 cafe0001", i_ready, i_rdata);
        end
        tick();
        n_total++;
        if (m_req !== 1'b0) begin
            n_bad++; $display("FAIL b2b_no_dup: m_req=%b m_addr=%h want m_req 0", m_req, m_addr);
        end
        tick();
        n_total++;
        if (m_req !== 1'b1 || m_addr !== 32'h404) begin
            n_bad++; $display("FAIL b2b_second: m_req=%b m_addr=%h want 1 00000404", m_req, m_addr);
        end
        m_ack = 1; m_rdata = 32'hCAFE0002;
        tick();
        m_ack = 0; i_req = 0;
        n_total++;
        if (i_ready !== 1'b1 || i_rdata !== 32'hCAFE0002) begin
            n_bad++; $display("FAIL b2b_ready2: i_ready=%b i_rdata=%h want 1 cafe0002", i_ready, i_rdata);
        end
        tick();
        n_total++;
        if (m_req !== 1'b0 || i_ready !== 1'b0) begin
            n_bad++; $display("FAIL b2b_idle: m_req=%b i_ready=%b want 0 0", m_req, i_ready);
        end
    endtask

    task automatic test_flush();
        i_req = 1; i_addr = 32'h800;
        tick();
        i_flush = 1; i_req = 0;
        n_total++;
        if (m_req !== 1'b1 || m_addr !== 32'h800) begin
            n_bad++; $display("FAIL flush_issue: m_req=%b m_addr=%h want 1 00000800", m_req, m_addr);
        end
        tick();
        i_flush = 0;
        n_total++;
        if (m_req !== 1'b1 || m_addr !== 32'h800) begin
            n_bad++; $display("FAIL flush_inflight: m_req=%b m_addr=%h want 1 00000800", m_req, m_addr);
        end
        m_ack = 1; m_rdata = 32'hAAAA5555;
        tick();
        m_ack = 0;
        n_total++;
        if (i_ready !== 1'b0 || i_rdata !== 32'hCAFE0002 || m_req !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_discard: i_ready=%b i_rdata=%h m_req=%b want 0 cafe0002 0", i_ready, i_rdata, m_req);
        end
        i_req = 1; i_addr = 32'h900;
        tick();
        n_total++;
        if (m_req !== 1'b1 || m_addr !== 32'h900) begin
            n_bad++; $display("FAIL flush_refetch: m_req=%b m_addr=%h want 1 00000900", m_req, m_addr);
        end
        m_ack = 1; m_rdata = 32'h90909090;
        tick();
        m_ack = 0; i_req = 0;
        n_total++;
        if (i_ready !== 1'b1 || i_rdata !== 32'h90909090) begin
            n_bad++; $display("FAIL flush_refetch_done: i_ready=%b i_rdata=%h want 1 90909090", i_ready, i_rdata);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'h0BADF00D; d_wstrb = 4'b1111;
        tick();
        n_total++;
        if (m_req !== 1'b1 || m_addr !== 32'h300) begin
            n_bad++; $display("FAIL midrst_issue: m_req=%b m_addr=%h want 1 00000300", m_req, m_addr);
        end
        rst = 1'b0;
        #1;
        n_total++;
        if (m_req !== 1'b0 || m_addr !== 32'h0 || m_we !== 1'b0 || d_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL midrst_async: m_req=%b m_addr=%h m_we=%b d_rdata=%h want 0 0 0 0",
                     m_req, m_addr, m_we, d_rdata);
        end
        d_req = 0;
        #2;
        rst = 1'b1;
        tick();
        m_ack = 1; m_rdata = 32'h55555555;
        tick();
        m_ack = 0;
        n_total++;
        if (d_ready !== 1'b0 || i_ready !== 1'b0 || d_rdata !== 32'h0 || m_req !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_stray_ack: d_ready=%b i_ready=%b d_rdata=%h m_req=%b want 0 0 0 0",
                     d_ready, i_ready, d_rdata, m_req);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_load();
        test_contention();
        test_back_to_back();
        test_flush();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
